// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned CELLS  = ROWS * COLS;

  // One full-scan verdict: a single clean key (hit=1) or nothing usable.
  typedef struct packed {
    logic              hit;
    logic [CODE_W-1:0] code;
  } scan_result_t;

  // Result used before any scan has completed; also the "no key" verdict.
  localparam scan_result_t NO_KEY = '0;

  // Column scan states; the encoding doubles as the column index.
  localparam logic [1:0] COL0 = 2'd0;
  localparam logic [1:0] COL1 = 2'd1;
  localparam logic [1:0] COL2 = 2'd2;
  localparam logic [1:0] COL3 = 2'd3;

  // Active-low one-hot column drive for a given scan state.
  function automatic logic [COLS-1:0] col_drive(input logic [1:0] state);
    return ~(COLS'(1) << state);
  endfunction

  // Reduce 16 samples (bit index row*COLS+col) to a scan verdict.
  // The bit index is the key code, so a lone hit reports its own position.
  // No-hit and multi-hit verdicts carry code 0 so they compare equal.
  function automatic scan_result_t evaluate_scan(input logic [CELLS-1:0] samples);
    scan_result_t r;
    int unsigned  hits;
    r    = NO_KEY;
    hits = 0;
    for (int unsigned i = 0; i < CELLS; i++) begin
      if (samples[i]) begin
        hits++;
        r.code = CODE_W'(i);
      end
    end
    if (hits == 1) begin
      r.hit = 1'b1;
    end else begin
      r.code = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Column-step prescaler: one-cycle tick every CLK_DIV clocks.
module scan_tick_gen #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned       CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Count 0..CLK_DIV-1 and wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with full-scan debounce and ghost rejection.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic              IN_clk,
  input  logic              IN_rst,
  input  logic [ROWS-1:0]   IN_row,
  output logic [COLS-1:0]   OUT_col,
  output logic [CODE_W-1:0] OUT_value,
  output logic              OUT_key
);

  localparam int unsigned      STB_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [STB_W-1:0] STB_MAX = STB_W'(DEBOUNCE_SCANS);
  localparam logic [STB_W-1:0] STB_ONE = STB_W'(1);

  logic               tick;
  logic [ROWS-1:0]    row_meta;
  logic [ROWS-1:0]    row_sync;
  logic [ROWS-1:0]    row_hit;
  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [COLS-1:0]    col;
  logic [CELLS-1:0]   acc;
  logic [CELLS-1:0]   acc_next;
  logic               scan_done;
  scan_result_t       result;
  scan_result_t       prev_result;
  logic [STB_W-1:0]   stable_cnt;
  logic [STB_W-1:0]   stable_next;
  logic               commit;
  logic               key;
  logic [CODE_W-1:0]  value;

  scan_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (IN_clk),
    .rst (IN_rst),
    .tick(tick)
  );

  // Two-flop synchronizer; reset to "all rows idle" (pulled up).
  always_ff @(posedge IN_clk or posedge IN_rst) begin
    if (IN_rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= IN_row;
      row_sync <= row_meta;
    end
  end

  assign row_hit = ~row_sync;

  // Next column state: COL0 -> COL1 -> COL2 -> COL3 -> COL0.
  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        COL0:    state_next = COL1;
        COL1:    state_next = COL2;
        COL2:    state_next = COL3;
        COL3:    state_next = COL0;
        default: state_next = COL0;
      endcase
    end
  end

  // Column FSM with a registered column drive.
  always_ff @(posedge IN_clk or posedge IN_rst) begin
    if (IN_rst) begin
      state <= COL0;
      col   <= col_drive(COL0);
    end else begin
      state <= state_next;
      col   <= col_drive(state_next);
    end
  end

  // Merge the current column's rows into the accumulator image. The scan
  // verdict is taken from this merged image so the column-3 samples latched
  // on the final tick are part of the same evaluation.
  always_comb begin
    acc_next = acc;
    if (tick) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (state == 2'(c)) begin
          for (int unsigned r = 0; r < ROWS; r++) begin
            acc_next[r*COLS + c] = row_hit[r];
          end
        end
      end
    end
  end

  // Row-hit accumulator, one bit per key position.
  always_ff @(posedge IN_clk or posedge IN_rst) begin
    if (IN_rst) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

  assign scan_done = tick && (state == COL3);
  assign result    = evaluate_scan(acc_next);

  // Stable-count update for a completed scan.
  always_comb begin
    stable_next = STB_ONE;
    if (result == prev_result) begin
      stable_next = (stable_cnt == STB_MAX) ? STB_MAX : stable_cnt + 1'b1;
    end
  end

  assign commit = scan_done && (stable_next == STB_MAX);

  // Debounce state, updated once per completed scan.
  always_ff @(posedge IN_clk or posedge IN_rst) begin
    if (IN_rst) begin
      prev_result <= NO_KEY;
      stable_cnt  <= '0;
    end else if (scan_done) begin
      prev_result <= result;
      stable_cnt  <= stable_next;
    end
  end

  // Committed outputs; the code is held across releases.
  always_ff @(posedge IN_clk or posedge IN_rst) begin
    if (IN_rst) begin
      key   <= 1'b0;
      value <= '0;
    end else if (commit) begin
      key <= result.hit;
      if (result.hit) begin
        value <= result.code;
      end
    end
  end

  assign OUT_col   = col;
  assign OUT_key   = key;
  assign OUT_value = value;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan with a behavioural 4x4 key matrix.
module tb_keypad_scan;

  localparam int unsigned CLK_DIV        = 4;
  localparam int unsigned DEBOUNCE_SCANS = 3;
  localparam int          COMMIT_BUDGET  = (DEBOUNCE_SCANS + 1) * 4 * CLK_DIV + 6;

  typedef struct packed {
    logic       key;
    logic [3:0] value;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  value;
  logic        key;
  logic [15:0] pressed;

  exp_t       sb_q[$];
  logic [3:0] col_q[$];

  int checks;
  int errors;

  keypad_scan #(
    .CLK_DIV(CLK_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) dut (
    .IN_clk   (clk),
    .IN_rst   (rst),
    .IN_row   (row),
    .OUT_col  (col),
    .OUT_value(value),
    .OUT_key  (key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4 + c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Wait (bounded) until OUT_key or OUT_value moves; no checking here.
  task automatic wait_output_change(input int budget, output bit timed_out);
    logic       k0;
    logic [3:0] v0;
    int         n;
    k0 = key;
    v0 = value;
    n = 0;
    timed_out = 1'b1;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (key !== k0 || value !== v0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [3:0] prev;
    logic [3:0] exp_col;
    int         n;
    rst = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b, expected 1110", col); end
    checks++;
    if (key !== 1'b0) begin errors++; $display("FAIL reset_key: got %b, expected 0", key); end
    checks++;
    if (value !== 4'h0) begin errors++; $display("FAIL reset_value: got %h, expected 0", value); end
    col_q.push_back(4'b1101);
    col_q.push_back(4'b1011);
    col_q.push_back(4'b0111);
    col_q.push_back(4'b1110);
    col_q.push_back(4'b1101);
    rst = 1'b0;
    while (col_q.size() > 0) begin
      prev = col;
      n = 0;
      while (col === prev && n < 8) begin
        @(negedge clk);
        n++;
      end
      exp_col = col_q.pop_front();
      checks++;
      if (col !== exp_col) begin errors++; $display("FAIL col_seq: got %b, expected %b", col, exp_col); end
      checks++;
      if (n != CLK_DIV) begin errors++; $display("FAIL col_period: got %0d clocks, expected %0d", n, CLK_DIV); end
    end
    checks++;
    if (key !== 1'b0 || value !== 4'h0) begin
      errors++; $display("FAIL idle_outputs: got key=%b value=%h, expected key=0 value=0", key, value);
    end
  endtask

  task automatic test_press_hold_release;
    exp_t e;
    bit   to;
    bit   moved;
    pressed[2*4 + 1] = 1'b1;
    sb_q.push_back('{key: 1'b1, value: 4'h9});
    wait_output_change(COMMIT_BUDGET, to);
    e = sb_q.pop_front();
    checks++;
    if (to) begin errors++; $display("FAIL press_timeout: no output change within %0d clocks", COMMIT_BUDGET); end
    checks++;
    if (key !== e.key || value !== e.value) begin
      errors++; $display("FAIL press_commit: got key=%b value=%h, expected key=%b value=%h", key, value, e.key, e.value);
    end
    moved = 1'b0;
    repeat (48) begin
      @(negedge clk);
      if (key !== 1'b1 || value !== 4'h9) moved = 1'b1;
    end
    checks++;
    if (moved) begin errors++; $display("FAIL hold_stable: got output movement while held, expected key=1 value=9"); end
    pressed = '0;
    sb_q.push_back('{key: 1'b0, value: 4'h9});
    wait_output_change(COMMIT_BUDGET, to);
    e = sb_q.pop_front();
    checks++;
    if (to) begin errors++; $display("FAIL release_timeout: no output change within %0d clocks", COMMIT_BUDGET); end
    checks++;
    if (key !== e.key || value !== e.value) begin
      errors++; $display("FAIL release_commit: got key=%b value=%h, expected key=%b value=%h", key, value, e.key, e.value);
    end
  endtask

  // Toggle period is 24 clocks so successive column-3 samples (every 16
  // clocks) never see the same level three scans in a row.
  task automatic test_bounce;
    exp_t e;
    bit   to;
    bit   rose;
    rose = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pressed[0*4 + 3] = ~pressed[0*4 + 3];
      repeat (12) begin
        @(negedge clk);
        if (key !== 1'b0) rose = 1'b1;
      end
    end
    checks++;
    if (rose) begin errors++; $display("FAIL bounce_quiet: got key=1 during bounce, expected key=0"); end
    pressed[0*4 + 3] = 1'b1;
    sb_q.push_back('{key: 1'b1, value: 4'h3});
    wait_output_change(COMMIT_BUDGET, to);
    e = sb_q.pop_front();
    checks++;
    if (to) begin errors++; $display("FAIL bounce_timeout: no output change within %0d clocks", COMMIT_BUDGET); end
    checks++;
    if (key !== e.key || value !== e.value) begin
      errors++; $display("FAIL bounce_commit: got key=%b value=%h, expected key=%b value=%h", key, value, e.key, e.value);
    end
  endtask

  task automatic test_multi_key;
    exp_t e;
    bit   to;
    bit   rose;
    pressed = '0;
    sb_q.push_back('{key: 1'b0, value: 4'h3});
    wait_output_change(COMMIT_BUDGET, to);
    e = sb_q.pop_front();
    checks++;
    if (to || key !== e.key || value !== e.value) begin
      errors++; $display("FAIL multi_pre_release: got key=%b value=%h timeout=%b, expected key=%b value=%h", key, value, to, e.key, e.value);
    end
    pressed[0*4 + 0] = 1'b1;
    pressed[3*4 + 3] = 1'b1;
    rose = 1'b0;
    repeat (64) begin
      @(negedge clk);
      if (key !== 1'b0) rose = 1'b1;
    end
    checks++;
    if (rose) begin errors++; $display("FAIL multi_reject: got key=1 with two keys held, expected key=0"); end
    pressed[3*4 + 3] = 1'b0;
    sb_q.push_back('{key: 1'b1, value: 4'h0});
    wait_output_change(COMMIT_BUDGET, to);
    e = sb_q.pop_front();
    checks++;
    if (to || key !== e.key || value !== e.value) begin
      errors++; $display("FAIL multi_single: got key=%b value=%h timeout=%b, expected key=%b value=%h", key, value, to, e.key, e.value);
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    bit   to;
    logic [3:0] prev;
    logic [3:0] exp_col;
    int         n;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (key !== 1'b0 || value !== 4'h0 || col !== 4'b1110) begin
      errors++; $display("FAIL async_reset: got key=%b value=%h col=%b, expected key=0 value=0 col=1110", key, value, col);
    end
    @(negedge clk);
    rst = 1'b0;
    col_q.push_back(4'b1101);
    prev = col;
    n = 0;
    while (col === prev && n < 8) begin
      @(negedge clk);
      n++;
    end
    exp_col = col_q.pop_front();
    checks++;
    if (col !== exp_col || n != CLK_DIV) begin
      errors++; $display("FAIL restart_col: got %b after %0d clocks, expected %b after %0d", col, n, exp_col, CLK_DIV);
    end
    sb_q.push_back('{key: 1'b1, value: 4'h0});
    wait_output_change(COMMIT_BUDGET, to);
    e = sb_q.pop_front();
    checks++;
    if (to || key !== e.key || value !== e.value) begin
      errors++; $display("FAIL restart_commit: got key=%b value=%h timeout=%b, expected key=%b value=%h", key, value, to, e.key, e.value);
    end
  endtask

  // Direct switch from one held key to another: key must stay high.
  task automatic test_back_to_back;
    exp_t e;
    bit   to;
    pressed = '0;
    pressed[1*4 + 2] = 1'b1;
    sb_q.push_back('{key: 1'b1, value: 4'h6});
    wait_output_change(COMMIT_BUDGET, to);
    e = sb_q.pop_front();
    checks++;
    if (to) begin errors++; $display("FAIL switch_timeout: no output change within %0d clocks", COMMIT_BUDGET); end
    checks++;
    if (key !== e.key || value !== e.value) begin
      errors++; $display("FAIL switch_commit: got key=%b value=%h, expected key=%b value=%h", key, value, e.key, e.value);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    pressed = '0;
    test_reset();
    test_press_hold_release();
    test_bounce();
    test_multi_key();
    test_async_reset();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0 || col_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0", sb_q.size(), col_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
